da_mac_engine: RTL and testbench

Parametrised distributed-arithmetic (DA) multiply-accumulate engine; next generation of the fixed 8-partition `da` block.
- Generalised in partition count, LUT address width, sample width, coefficient width and accumulator width.
- New over `da`: start/busy/done handshake, signed-or-unsigned sample mode, multi-pass accumulation for long filters, sticky overflow flag.
- Sits between the FIR sample shift register, which supplies one bit-slice per cycle, and the output formatter.

---
 rtl/da_mac_engine_pkg.sv | 33 +++
 rtl/da_mac_engine_if.sv | 32 +++
 rtl/da_mac_engine_lut.sv | 27 ++
 rtl/da_mac_engine.sv | 179 +++++++++++++++++
 tb/tb_da_mac_engine.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/da_mac_engine_pkg.sv
// Shared definitions for the distributed-arithmetic MAC engine:
// width helpers, default partition count and the sequencer state encoding.
`timescale 1ns/1ps
package da_pkg;

   // Ceiling log2; returns 0 for values of 0 or 1.
   function automatic int clog2(input int value);
      int result;
      int rest;
      result = 32'sd0;
      rest   = value - 32'sd1;
      while (rest > 32'sd0) begin
         result = result + 32'sd1;
         rest   = rest >>> 32'sd1;
      end
      return result;
   endfunction

   // Width of the partition adder tree: one LUT word plus carry growth.
   function automatic int tree_w(input int coef_w, input int num_roms);
      return coef_w + clog2(num_roms);
   endfunction

   localparam int NUM_ROMS_DEF = 32'sd8;
   localparam int ROM_SEL_W    = clog2(NUM_ROMS_DEF);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

endpackage

// File: rtl/da_mac_engine_if.sv
// Handshake, slice and coefficient-load bundle of the DA MAC engine.
// master = sample shift register / controller side, slave = engine.
`timescale 1ns/1ps
interface da_mac_engine_if #(
   parameter int NUM_ROMS = 8,
   parameter int ADDR_W   = 8,
   parameter int COEF_W   = 19,
   parameter int ACC_W    = 38
);
   localparam int CADDR_W = da_pkg::clog2(NUM_ROMS) + ADDR_W;

   logic                         start;
   logic                         accum;
   logic [NUM_ROMS*ADDR_W-1:0]   slice_in;
   logic                         cload;
   logic [CADDR_W-1:0]           caddr;
   logic [COEF_W-1:0]            cin;
   logic                         busy;
   logic                         done;
   logic [ACC_W-1:0]             acc_out;
   logic                         ovf;

   modport master (
      output start, accum, slice_in, cload, caddr, cin,
      input  busy, done, acc_out, ovf
   );

   modport slave (
      input  start, accum, slice_in, cload, caddr, cin,
      output busy, done, acc_out, ovf
   );
endinterface

// File: rtl/da_mac_engine_lut.sv
// One DA coefficient partition: synchronous write port and registered read port.
// Storage has no reset so coefficients survive a resetn pulse.
`timescale 1ns/1ps
module da_lut #(
   parameter int ADDR_W = 8,
   parameter int COEF_W = 19
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [COEF_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [COEF_W-1:0] rdata
);
   logic [COEF_W-1:0] mem_r [0:(2**ADDR_W)-1];
   logic [COEF_W-1:0] rdata_r;

   // coefficient write and registered read; a same-address read returns the old word
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
      rdata_r <= mem_r[raddr];
   end

   assign rdata = rdata_r;
endmodule

// File: rtl/da_mac_engine.sv
// Distributed-arithmetic MAC engine. One bit-slice per cycle (LSB first)
// addresses NUM_ROMS coefficient partitions; the partition words are summed
// and shift-accumulated. Pipeline: slice -> LUT read reg -> tree sum reg -> acc.
`timescale 1ns/1ps
module da_mac_engine
   import da_pkg::*;
#(
   parameter int NUM_ROMS  = 8,
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 12,
   parameter int COEF_W    = 19,
   parameter int ACC_W     = 38,
   parameter bit SIGNED_IN = 1'b1
) (
   input logic           clk,
   input logic           resetn,
   da_mac_engine_if.slave bus
);
   localparam int SEL_W  = clog2(NUM_ROMS);
   localparam int TREE_W = tree_w(COEF_W, NUM_ROMS);
   localparam int CNT_W  = clog2(DATA_W + 1);
   localparam int EXT_W  = ACC_W + DATA_W + 1;
   localparam logic [CNT_W-1:0] K_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] K_ONE  = CNT_W'(1);

   state_e                           state_r, state_s;
   logic [CNT_W-1:0]                 cnt_r, cnt_s;
   logic                             accept_s, sample_s, busy_s, last_step_s, wr_en_s;
   logic                             busy_r, done_r, ovf_r;
   logic                             v1_r, v2_r;
   logic [CNT_W-1:0]                 k1_r, k2_r;
   logic [NUM_ROMS-1:0][COEF_W-1:0]  rd_data_s;
   logic signed [TREE_W-1:0]         tree_sum_s, sum_r;
   logic signed [EXT_W-1:0]          term_s, acc_ext_s, res_s;
   logic signed [ACC_W-1:0]          acc_r, acc_step_s;
   logic [ACC_W-1:0]                 acc_out_r;
   logic                             ovf_step_s;

   // Coefficient loads only land while idle and not starting; a partition
   // index with no matching instance simply enables nothing.
   assign wr_en_s = bus.cload & ~bus.start & ~busy_r;

   for (genvar r = 0; r < NUM_ROMS; r++) begin : g_lut
      da_lut #(.ADDR_W(ADDR_W), .COEF_W(COEF_W)) u_lut (
         .clk   (clk),
         .we    (wr_en_s & (bus.caddr[ADDR_W +: SEL_W] == SEL_W'(r))),
         .waddr (bus.caddr[ADDR_W-1:0]),
         .wdata (bus.cin),
         .raddr (bus.slice_in[r*ADDR_W +: ADDR_W]),
         .rdata (rd_data_s[r])
      );
   end

   // sequencer state and slice counter register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r <= IDLE;
         cnt_r   <= '0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
      end
   end

   // next-state: IDLE -> RUN for slices 1..DATA_W-1 -> DRAIN for two cycles
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_s = RUN;
               cnt_s   = K_ONE;
            end else begin
               cnt_s   = '0;
            end
         end
         RUN: begin
            if (cnt_r == K_LAST) begin
               state_s = DRAIN;
               cnt_s   = '0;
            end else begin
               cnt_s   = cnt_r + K_ONE;
            end
         end
         DRAIN: begin
            if (cnt_r == K_ONE) begin
               state_s = IDLE;
               cnt_s   = '0;
            end else begin
               cnt_s   = cnt_r + K_ONE;
            end
         end
         default: begin
            state_s = IDLE;
            cnt_s   = '0;
         end
      endcase
   end

   // control decode; busy stays up through the done cycle so a start there is refused
   always_comb begin
      accept_s    = bus.start & ~busy_r & (state_r == IDLE);
      sample_s    = accept_s | (state_r == RUN);
      last_step_s = v2_r & (k2_r == K_LAST);
      busy_s      = (state_s != IDLE) | last_step_s;
   end

   // partition adder tree on the registered LUT words
   always_comb begin
      tree_sum_s = '0;
      for (int i = 0; i < NUM_ROMS; i++) begin
         tree_sum_s = tree_sum_s + TREE_W'($signed(rd_data_s[i]));
      end
   end

   // pipeline tags (valid, slice index) and the registered tree sum
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         v1_r  <= 1'b0;
         k1_r  <= '0;
         v2_r  <= 1'b0;
         k2_r  <= '0;
         sum_r <= '0;
      end else begin
         v1_r  <= sample_s;
         k1_r  <= cnt_r;
         v2_r  <= v1_r;
         k2_r  <= k1_r;
         sum_r <= tree_sum_s;
      end
   end

   // weighted accumulate in extended width; MSB slice is subtracted for signed samples
   always_comb begin
      term_s    = EXT_W'(sum_r) <<< k2_r;
      acc_ext_s = EXT_W'(acc_r);
      if (SIGNED_IN && (k2_r == K_LAST)) begin
         res_s = acc_ext_s - term_s;
      end else begin
         res_s = acc_ext_s + term_s;
      end
      acc_step_s = res_s[ACC_W-1:0];
      ovf_step_s = (EXT_W'(acc_step_s) != res_s);
   end

   // accumulator seed/update, result register and status flags
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         acc_r     <= '0;
         acc_out_r <= '0;
         ovf_r     <= 1'b0;
         done_r    <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         busy_r <= busy_s;
         done_r <= last_step_s;
         if (accept_s) begin
            acc_r <= bus.accum ? acc_out_r : '0;
            if (!bus.accum) begin
               ovf_r <= 1'b0;
            end
         end else if (v2_r) begin
            acc_r <= acc_step_s;
            if (ovf_step_s) begin
               ovf_r <= 1'b1;
            end
            if (last_step_s) begin
               acc_out_r <= acc_step_s;
            end
         end
      end
   end

   assign bus.busy    = busy_r;
   assign bus.done    = done_r;
   assign bus.acc_out = acc_out_r;
   assign bus.ovf     = ovf_r;
endmodule

// File: tb/tb_da_mac_engine.sv
// Directed bench for da_mac_engine: three instances (unsigned 38-bit, signed
// 38-bit, unsigned 24-bit) share one stimulus stream and are checked against
// hand-computed results.
`timescale 1ns/1ps
module tb_da_mac_engine;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start, accum, cload;
   logic [63:0] slice_in;
   logic [10:0] caddr;
   logic [18:0] cin;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   da_mac_engine_if #(.NUM_ROMS(8), .ADDR_W(8), .COEF_W(19), .ACC_W(38)) if_u ();
   da_mac_engine_if #(.NUM_ROMS(8), .ADDR_W(8), .COEF_W(19), .ACC_W(38)) if_s ();
   da_mac_engine_if #(.NUM_ROMS(8), .ADDR_W(8), .COEF_W(19), .ACC_W(24)) if_n ();

   assign if_u.start = start;  assign if_u.accum = accum;  assign if_u.slice_in = slice_in;
   assign if_u.cload = cload;  assign if_u.caddr = caddr;  assign if_u.cin = cin;
   assign if_s.start = start;  assign if_s.accum = accum;  assign if_s.slice_in = slice_in;
   assign if_s.cload = cload;  assign if_s.caddr = caddr;  assign if_s.cin = cin;
   assign if_n.start = start;  assign if_n.accum = accum;  assign if_n.slice_in = slice_in;
   assign if_n.cload = cload;  assign if_n.caddr = caddr;  assign if_n.cin = cin;

   da_mac_engine #(.NUM_ROMS(8), .ADDR_W(8), .DATA_W(12), .COEF_W(19), .ACC_W(38), .SIGNED_IN(1'b0))
      u_uns (.clk(clk), .resetn(resetn), .bus(if_u));
   da_mac_engine #(.NUM_ROMS(8), .ADDR_W(8), .DATA_W(12), .COEF_W(19), .ACC_W(38), .SIGNED_IN(1'b1))
      u_sgn (.clk(clk), .resetn(resetn), .bus(if_s));
   da_mac_engine #(.NUM_ROMS(8), .ADDR_W(8), .DATA_W(12), .COEF_W(19), .ACC_W(24), .SIGNED_IN(1'b0))
      u_nar (.clk(clk), .resetn(resetn), .bus(if_n));

   typedef struct {
      logic [63:0] slice;
      logic        accum;
      logic [37:0] exp_u;
      logic [37:0] exp_s;
      logic [23:0] exp_n;
      logic        ovf_n;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic write_lut(input int p, input int a, input logic [18:0] d);
      cload = 1'b1;
      caddr = {3'(p), 8'(a)};
      cin   = d;
      @(negedge clk);
      cload = 1'b0;
   endtask

   // Called mid-cycle; that cycle is the start cycle (cycle 0). Returns mid-cycle 15.
   task automatic run_pass(input string tag, input logic [63:0] sl, input logic acc_i,
                           input int inj_cyc, input logic cl_start);
      logic [15:0] busy_map, done_u, done_s, done_n;
      busy_map = '0; done_u = '0; done_s = '0; done_n = '0;
      start    = 1'b1;
      accum    = acc_i;
      slice_in = sl;
      if (cl_start) begin
         cload = 1'b1; caddr = 11'd1; cin = 19'd5;
      end
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk);
         busy_map[c] = if_u.busy;
         done_u[c]   = if_u.done;
         done_s[c]   = if_s.done;
         done_n[c]   = if_n.done;
         start = 1'b0;
         cload = 1'b0;
         if (c == inj_cyc) begin
            start = 1'b1; cload = 1'b1; caddr = 11'd1; cin = 19'd5;
         end
      end
      check({tag, "_busy_map"}, 64'(busy_map), 64'h7FFE);
      check({tag, "_done_u"},   64'(done_u),   64'h4000);
      check({tag, "_done_s"},   64'(done_s),   64'h4000);
      check({tag, "_done_n"},   64'(done_n),   64'h4000);
   endtask

   initial begin
      int dcount;
      start = 1'b0; accum = 1'b0; cload = 1'b0;
      slice_in = 64'h0; caddr = 11'h0; cin = 19'h0;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(if_u.busy), 64'h0);
      check("rst_done", 64'(if_u.done), 64'h0);
      check("rst_acc",  64'(if_u.acc_out), 64'h0);
      check("rst_ovf",  64'(if_n.ovf), 64'h0);
      resetn = 1'b1;
      @(negedge clk);

      // coefficient image: all zero, P0[1]=1, P1[2]=-3, Pr[0xFF]=262143
      for (int p = 0; p < 8; p++) begin
         for (int a = 0; a < 256; a++) begin
            write_lut(p, a, 19'h0);
         end
      end
      write_lut(0, 1, 19'd1);
      write_lut(1, 2, 19'h7FFFD);
      for (int p = 0; p < 8; p++) begin
         write_lut(p, 255, 19'h3FFFF);
      end

      // S per slice: 64'h1 -> 1, 64'h200 -> -3, 64'h201 -> -2, all ones -> 2097144
      vecs[0] = '{64'h1, 1'b0, 38'd4095, 38'h3F_FFFF_FFFF, 24'd4095, 1'b0};
      vecs[1] = '{64'h1, 1'b1, 38'd8190, 38'h3F_FFFF_FFFE, 24'd8190, 1'b0};
      vecs[2] = '{64'h200, 1'b0, 38'h3F_FFFF_D003, 38'd3, 24'hFF_D003, 1'b0};
      vecs[3] = '{64'h201, 1'b1, 38'h3F_FFFF_B005, 38'd5, 24'hFF_B005, 1'b0};
      vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 38'h1_FFDF_8008, 38'h3F_FFE0_0008, 24'hDF_8008, 1'b1};
      vecs[5] = '{64'h1, 1'b1, 38'h1_FFDF_9007, 38'h3F_FFE0_0007, 24'hDF_9007, 1'b1};
      vecs[6] = '{64'h1, 1'b0, 38'd4095, 38'h3F_FFFF_FFFF, 24'd4095, 1'b0};

      // table passes run back to back: each start lands in the cycle after done
      for (int i = 0; i < 7; i++) begin
         run_pass($sformatf("row%0d", i), vecs[i].slice, vecs[i].accum, -1, 1'b0);
         check($sformatf("row%0d_acc_u", i), 64'(if_u.acc_out), 64'(vecs[i].exp_u));
         check($sformatf("row%0d_acc_s", i), 64'(if_s.acc_out), 64'(vecs[i].exp_s));
         check($sformatf("row%0d_acc_n", i), 64'(if_n.acc_out), 64'(vecs[i].exp_n));
         check($sformatf("row%0d_ovf_u", i), 64'(if_u.ovf), 64'h0);
         check($sformatf("row%0d_ovf_s", i), 64'(if_s.ovf), 64'h0);
         check($sformatf("row%0d_ovf_n", i), 64'(if_n.ovf), 64'(vecs[i].ovf_n));
      end

      // start + cload pulsed mid-pass, in the done cycle, and cload alongside start
      run_pass("inj5", 64'h1, 1'b0, 5, 1'b0);
      check("inj5_acc_u", 64'(if_u.acc_out), 64'd4095);
      run_pass("inj14", 64'h1, 1'b0, 14, 1'b0);
      check("inj14_acc_u", 64'(if_u.acc_out), 64'd4095);
      run_pass("clst", 64'h1, 1'b0, -1, 1'b1);
      check("clst_acc_u", 64'(if_u.acc_out), 64'd4095);
      run_pass("after", 64'h1, 1'b0, -1, 1'b0);
      check("after_acc_u", 64'(if_u.acc_out), 64'd4095);
      check("after_acc_s", 64'(if_s.acc_out), 64'h3F_FFFF_FFFF);

      // set up nonzero result and ovf, then reset in cycle 5 of the next pass
      run_pass("pre_rst", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, -1, 1'b0);
      check("pre_rst_ovf_n", 64'(if_n.ovf), 64'h1);
      start = 1'b1; accum = 1'b0; slice_in = 64'h1;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      check("mid_busy", 64'(if_u.busy), 64'h1);
      resetn = 1'b0;
      #1;
      check("arst_busy",  64'(if_u.busy), 64'h0);
      check("arst_done",  64'(if_u.done), 64'h0);
      check("arst_acc_u", 64'(if_u.acc_out), 64'h0);
      check("arst_acc_n", 64'(if_n.acc_out), 64'h0);
      check("arst_ovf_n", 64'(if_n.ovf), 64'h0);
      @(negedge clk);
      resetn = 1'b1;
      dcount = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         dcount = dcount + int'(if_u.done) + int'(if_s.done) + int'(if_n.done);
      end
      check("arst_no_done", 64'(dcount), 64'h0);

      // coefficients survive reset
      run_pass("rerun", 64'h1, 1'b0, -1, 1'b0);
      check("rerun_acc_u", 64'(if_u.acc_out), 64'd4095);
      check("rerun_acc_s", 64'(if_s.acc_out), 64'h3F_FFFF_FFFF);
      check("rerun_acc_n", 64'(if_n.acc_out), 64'd4095);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
